// File: rtl/memory_port_arbiter.sv
// Arbitrates the single memory port between the load unit and the store-buffer drain.
// Optional `ARBITER_STATS_EN adds grant/starvation statistics counters.
module memory_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        ld_request_i,
   input  logic [31:0] ld_address_i,
   input  logic [1:0]  ld_width_i,
   output logic [31:0] ld_data_o,
   output logic        ld_done_o,
   input  logic        st_request_i,
   input  logic [31:0] st_address_i,
   input  logic [31:0] st_data_i,
   input  logic [1:0]  st_width_i,
   input  logic        st_buffer_full_i,
   output logic        st_done_o,
   output logic        mem_request_o,
   output logic        mem_write_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_data_o,
   output logic [1:0]  mem_width_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_done_i,
`ifdef ARBITER_STATS_EN
   output logic [31:0] ld_grant_count_o,
   output logic [31:0] st_grant_count_o,
   output logic [31:0] starve_event_count_o,
`endif
   output logic        idle_o
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT} state_t;

   state_t        state;
   logic [CW-1:0] starve_cnt;
   logic          drop;
   logic          starved;
   logic          st_grant;
   logic          ld_grant;

   // Stores win when forced (full buffer / starvation) or when no load competes.
   assign starved  = (starve_cnt == LIMIT);
   assign st_grant = (state == IDLE) && st_request_i &&
                     (st_buffer_full_i || starved || !ld_request_i || flush_i);
   assign ld_grant = (state == IDLE) && !st_grant && ld_request_i && !flush_i;

   // Completion is a combinational pass-through of the memory's done pulse.
   assign ld_done_o = (state == LD_WAIT) && mem_done_i && !drop && !flush_i;
   assign ld_data_o = ld_done_o ? mem_data_i : '0;
   assign st_done_o = (state == ST_WAIT) && mem_done_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state                <= IDLE;
         idle_o               <= 1'b1;
         mem_request_o        <= 1'b0;
         mem_write_o          <= 1'b0;
         mem_address_o        <= '0;
         mem_data_o           <= '0;
         mem_width_o          <= '0;
         drop                 <= 1'b0;
         starve_cnt           <= '0;
`ifdef ARBITER_STATS_EN
         ld_grant_count_o     <= '0;
         st_grant_count_o     <= '0;
         starve_event_count_o <= '0;
`endif
      end else begin
         mem_request_o <= 1'b0;

         if (!st_request_i || st_grant)
            starve_cnt <= '0;
         else if (ld_grant && !starved)
            starve_cnt <= starve_cnt + CW'(1);

         case (state)
            IDLE: begin
               if (st_grant) begin
                  state         <= ST_ISSUE;
                  idle_o        <= 1'b0;
                  mem_request_o <= 1'b1;
                  mem_write_o   <= 1'b1;
                  mem_address_o <= st_address_i;
                  mem_data_o    <= st_data_i;
                  mem_width_o   <= st_width_i;
               end else if (ld_grant) begin
                  state         <= LD_ISSUE;
                  idle_o        <= 1'b0;
                  mem_request_o <= 1'b1;
                  mem_write_o   <= 1'b0;
                  mem_address_o <= ld_address_i;
                  mem_width_o   <= ld_width_i;
               end
            end
            LD_ISSUE: begin
               state <= LD_WAIT;
               if (flush_i) drop <= 1'b1;
            end
            LD_WAIT: begin
               if (mem_done_i) begin
                  state  <= IDLE;
                  idle_o <= 1'b1;
                  drop   <= 1'b0;
               end else if (flush_i) begin
                  drop <= 1'b1;
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               if (mem_done_i) begin
                  state  <= IDLE;
                  idle_o <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               idle_o <= 1'b1;
            end
         endcase

`ifdef ARBITER_STATS_EN
         if (ld_grant) ld_grant_count_o <= ld_grant_count_o + 32'd1;
         if (st_grant) st_grant_count_o <= st_grant_count_o + 32'd1;
         if (st_grant && starved) starve_event_count_o <= starve_event_count_o + 32'd1;
`endif
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed grant orders and data.
module tb_memory_port_arbiter;
   localparam int LIM = 4;

   logic        clk_i = 1'b0;
   logic        rst_i, flush_i;
   logic        ld_request_i, st_request_i, st_buffer_full_i;
   logic [31:0] ld_address_i, st_address_i, st_data_i;
   logic [1:0]  ld_width_i, st_width_i;
   logic [31:0] ld_data_o, mem_address_o, mem_data_o, mem_data_i;
   logic        ld_done_o, st_done_o, mem_request_o, mem_write_o, mem_done_i, idle_o;
   logic [1:0]  mem_width_o;
`ifdef ARBITER_STATS_EN
   logic [31:0] ld_grant_count_o, st_grant_count_o, starve_event_count_o;
`endif

   always #5 clk_i = ~clk_i;

   memory_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .ld_request_i(ld_request_i), .ld_address_i(ld_address_i), .ld_width_i(ld_width_i),
      .ld_data_o(ld_data_o), .ld_done_o(ld_done_o),
      .st_request_i(st_request_i), .st_address_i(st_address_i), .st_data_i(st_data_i),
      .st_width_i(st_width_i), .st_buffer_full_i(st_buffer_full_i), .st_done_o(st_done_o),
      .mem_request_o(mem_request_o), .mem_write_o(mem_write_o),
      .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_width_o(mem_width_o),
      .mem_data_i(mem_data_i), .mem_done_i(mem_done_i),
`ifdef ARBITER_STATS_EN
      .ld_grant_count_o(ld_grant_count_o), .st_grant_count_o(st_grant_count_o),
      .starve_event_count_o(starve_event_count_o),
`endif
      .idle_o(idle_o)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_s(input string nm, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
      end
   endtask

   // Requester / memory stimulus state
   int   ld_target = 0, ld_cancel = 0, st_target = 0, lat = 3;
   logic stray = 1'b0;
   // Observations (written only by the monitor)
   int          ld_done_cnt = 0, st_done_cnt = 0, mdone_cnt = 0, cyc = 0, req_cyc = 0, ldd_cyc = 0;
   logic [31:0] ld_last = '0;
   string       glog = "";
   int          rsp_cnt = 0;

   // Requesters: hold a request until its done pulse, then present the next one.
   initial forever begin
      ld_request_i = (ld_done_cnt + ld_cancel) < ld_target;
      ld_address_i = 32'h100 + 32'(ld_done_cnt * 4);
      ld_width_i   = 2'(ld_done_cnt);
      st_request_i = st_done_cnt < st_target;
      st_address_i = 32'h2000 + 32'(st_done_cnt * 8);
      st_data_i    = 32'h5A00_0000 + 32'(st_done_cnt);
      st_width_i   = 2'(st_done_cnt + 1);
      @(posedge clk_i); #1;
   end

   // Memory: completes `lat` cycles after each request; data derived from the address.
   initial begin
      mem_done_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i) rsp_cnt = 0;
         else if (mem_request_o) rsp_cnt = lat;
         @(posedge clk_i); #1;
         mem_done_i = stray;
         mem_data_i = '0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               mem_done_i = 1'b1;
               mem_data_i = mem_address_o ^ 32'hDEAD_0000;
            end
         end
      end
   end

   // Model: one outstanding transaction, tracked by kind and age since grant.
   bit          m_valid = 0, m_busy = 0, m_st = 0, m_drop = 0;
   int          m_age = 0, m_starve = 0;
   logic [31:0] m_addr = '0, m_data = '0;
   logic [1:0]  m_width = '0;
   logic [31:0] m_ldc = '0, m_stc = '0, m_sev = '0;
   bit          e_req, e_wait, e_ldd, e_std, st_go, ld_go;

   always @(negedge clk_i) begin
      cyc++;
      e_req  = m_busy && (m_age == 0);
      e_wait = m_busy && (m_age >= 1);
      e_ldd  = e_wait && !m_st && mem_done_i && !m_drop && !flush_i;
      e_std  = e_wait && m_st && mem_done_i;
      if (m_valid) begin
         chk("idle", 32'(idle_o), 32'(!m_busy));
         chk("mem_req", 32'(mem_request_o), 32'(e_req));
         chk("ld_done", 32'(ld_done_o), 32'(e_ldd));
         chk("st_done", 32'(st_done_o), 32'(e_std));
         if (e_ldd) chk("ld_data", ld_data_o, mem_data_i);
         if (m_busy) begin
            chk("mem_write", 32'(mem_write_o), 32'(m_st));
            chk("mem_addr", mem_address_o, m_addr);
            chk("mem_width", 32'(mem_width_o), 32'(m_width));
            if (m_st) chk("mem_data", mem_data_o, m_data);
         end
`ifdef ARBITER_STATS_EN
         chk("ld_grants", ld_grant_count_o, m_ldc);
         chk("st_grants", st_grant_count_o, m_stc);
         chk("starve_events", starve_event_count_o, m_sev);
`endif
      end

      if (mem_request_o) begin glog = {glog, mem_write_o ? "S" : "L"}; req_cyc = cyc; end
      if (ld_done_o) begin ld_done_cnt++; ld_last = ld_data_o; ldd_cyc = cyc; end
      if (st_done_o) st_done_cnt++;
      if (mem_done_i) mdone_cnt++;

      if (rst_i) begin
         m_valid = 1; m_busy = 0; m_drop = 0; m_starve = 0;
         m_addr = '0; m_data = '0; m_width = '0;
         m_ldc = '0; m_stc = '0; m_sev = '0;
      end else if (m_valid) begin
         if (!m_busy) begin
            st_go = st_request_i && (st_buffer_full_i || m_starve == LIM || !ld_request_i || flush_i);
            ld_go = !st_go && ld_request_i && !flush_i;
            if (st_go) begin
               if (m_starve == LIM) m_sev++;
               m_stc++;
               m_busy = 1; m_st = 1; m_age = 0; m_starve = 0;
               m_addr = st_address_i; m_data = st_data_i; m_width = st_width_i;
            end else if (ld_go) begin
               m_ldc++;
               m_busy = 1; m_st = 0; m_age = 0;
               m_addr = ld_address_i; m_width = ld_width_i;
               m_starve = st_request_i ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
            end else if (!st_request_i) m_starve = 0;
         end else begin
            if (!st_request_i) m_starve = 0;
            if (!m_st && flush_i) m_drop = 1;
            if (m_age >= 1 && mem_done_i) begin m_busy = 0; m_drop = 0; end
            m_age++;
         end
      end
   end

   task automatic wait_quiet(input string nm);
      bit ok = 0;
      repeat (2) @(posedge clk_i);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_i);
         if (!ld_request_i && !st_request_i && idle_o && rsp_cnt == 0) begin ok = 1; break; end
      end
      chk({nm, "_quiet"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_req(input string nm);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (mem_request_o) begin ok = 1; break; end
      end
      chk({nm, "_req_seen"}, 32'(ok), 32'd1);
   endtask

   function automatic string since(input int s);
      return (glog.len() > s) ? glog.substr(s, glog.len() - 1) : "";
   endfunction

   initial begin
      int s, n, md;
      rst_i = 1'b1; flush_i = 1'b0; st_buffer_full_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_idle", 32'(idle_o), 32'd1);
      chk("rst_mem_req", 32'(mem_request_o), 32'd0);

      // Single load, 3-cycle memory latency
      s = glog.len(); ld_target = 1;
      wait_quiet("t1");
      chk_s("t1_order", since(s), "L");
      chk("t1_data", ld_last, 32'hDEAD_0100);
      chk("t1_latency", 32'(ldd_cyc - req_cyc), 32'd3);
      chk("t1_ld_cnt", 32'(ld_done_cnt), 32'd1);

      // Loads and stores both pending: starvation limit forces every fifth grant
      s = glog.len(); ld_target += 10; st_target += 2;
      wait_quiet("t2");
      chk_s("t2_order", since(s), "LLLLSLLLLSLL");
      chk("t2_st_cnt", 32'(st_done_cnt), 32'd2);
      chk("t2_ld_cnt", 32'(ld_done_cnt), 32'd11);

      // Full store buffer beats a pending load
      s = glog.len(); st_buffer_full_i = 1'b1; ld_target += 1; st_target += 1;
      wait_quiet("t3");
      st_buffer_full_i = 1'b0;
      chk_s("t3_order", since(s), "SL");
      chk("t3_st_cnt", 32'(st_done_cnt), 32'd3);

      // Flush during LD_WAIT: port transaction completes, delivery suppressed
      n = ld_done_cnt; md = mdone_cnt; s = glog.len(); lat = 3; ld_target += 1;
      wait_req("t4");
      @(posedge clk_i); #1 flush_i = 1'b1; ld_cancel++;
      @(posedge clk_i); #1 flush_i = 1'b0;
      wait_quiet("t4");
      chk_s("t4_order", since(s), "L");
      chk("t4_no_ld_done", 32'(ld_done_cnt), 32'(n));
      chk("t4_mem_done", 32'(mdone_cnt - md), 32'd1);

      // Flush in the same cycle as mem_done_i
      n = ld_done_cnt; md = mdone_cnt; lat = 1; ld_target += 1;
      wait_req("t4b");
      @(posedge clk_i); #1 flush_i = 1'b1; ld_cancel++;
      @(posedge clk_i); #1 flush_i = 1'b0;
      wait_quiet("t4b");
      chk("t4b_no_ld_done", 32'(ld_done_cnt), 32'(n));
      chk("t4b_mem_done", 32'(mdone_cnt - md), 32'd1);

      // Stray mem_done_i while idle is ignored
      n = ld_done_cnt; s = glog.len();
      @(posedge clk_i); #1 stray = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 stray = 1'b0;
      @(negedge clk_i);
      chk("t5_idle", 32'(idle_o), 32'd1);
      chk("t5_no_done", 32'(ld_done_cnt), 32'(n));
      chk_s("t5_no_req", since(s), "");

      // Reset while a store waits: abandoned, then re-issued
      lat = 5; s = glog.len(); st_target += 1;
      wait_req("t6");
      @(posedge clk_i); #1 rst_i = 1'b1;
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("t6_idle", 32'(idle_o), 32'd1);
      chk("t6_mem_req", 32'(mem_request_o), 32'd0);
      chk("t6_st_done", 32'(st_done_o), 32'd0);
      chk("t6_ld_done", 32'(ld_done_o), 32'd0);
      wait_quiet("t6");
      chk_s("t6_order", since(s), "SS");

      // Fresh reset, then 5 loads + 2 stores
      @(posedge clk_i); #1 rst_i = 1'b1;
      @(posedge clk_i); #1 rst_i = 1'b0;
      lat = 2; s = glog.len(); ld_target += 5; st_target += 2;
      wait_quiet("t7");
      chk_s("t7_order", since(s), "LLLLSLS");
`ifdef ARBITER_STATS_EN
      chk("t7_ld_grants", ld_grant_count_o, 32'd5);
      chk("t7_st_grants", st_grant_count_o, 32'd2);
      chk("t7_starve_events", starve_event_count_o, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
